// File: rtl/seg_scan_arbiter.sv
// Shares a 4-digit seven-segment display between two pattern sources. Grants change only at
// full-scan boundaries. Optional anode ghost blanking: define SEG_SCAN_GHOST_BLANK_EN.
module seg_scan_arbiter #(
    parameter int unsigned REFRESH_COUNT_MAX = 50000,
    parameter int unsigned HOLD_SCANS        = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [1:0]  req_i,
    input  logic [31:0] src0_dig_i,
    input  logic [31:0] src1_dig_i,
    output logic [1:0]  gnt_o,
    output logic [3:0]  an_o,
    output logic [7:0]  seg_o
);

    localparam int unsigned CNT_W  = $clog2(REFRESH_COUNT_MAX + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_SCANS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(REFRESH_COUNT_MAX);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_SCANS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic [1:0]         idx_q, idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               last_q, last_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         seg_q, seg_d;

    logic               tick_c;
    logic               boundary_c;
    logic               hold_done_c;
    logic [31:0]        sel_dig_c;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            idx_q   <= 2'd0;
            hold_q  <= '0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            an_q    <= 4'hF;
            seg_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    // Scan timing, arbitration and display output path
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        last_d      = last_q;
        presc_d     = presc_q + CNT_W'(1);
        idx_d       = idx_q;
        gnt_d       = 2'b00;
        an_d        = 4'hF;
        seg_d       = 8'hFF;
        sel_dig_c   = src0_dig_i;

        tick_c      = (presc_q == CNT_MAX);
        boundary_c  = tick_c && (idx_q == 2'd3);
        hold_done_c = ((32'(hold_q) + 32'd1) >= HOLD_SCANS);

        if (tick_c) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end

        if (boundary_c) begin
            case (state_q)
                ST_IDLE: begin
                    case (req_i)
                        2'b01:   state_d = ST_OWN0;
                        2'b10:   state_d = ST_OWN1;
                        2'b11:   state_d = last_q ? ST_OWN0 : ST_OWN1;
                        default: state_d = ST_IDLE;
                    endcase
                end
                ST_OWN0: begin
                    if (!req_i[0]) begin
                        state_d = req_i[1] ? ST_OWN1 : ST_IDLE;
                    end else if (req_i[1] && hold_done_c) begin
                        state_d = ST_OWN1;
                    end
                end
                ST_OWN1: begin
                    if (!req_i[1]) begin
                        state_d = req_i[0] ? ST_OWN0 : ST_IDLE;
                    end else if (req_i[0] && hold_done_c) begin
                        state_d = ST_OWN0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (state_d != state_q) begin
                hold_d = '0;
            end else if ((state_q != ST_IDLE) && (hold_q != HOLD_MAX)) begin
                hold_d = hold_q + HOLD_W'(1);
            end

            if ((state_d == ST_OWN0) && (state_q != ST_OWN0)) begin
                last_d = 1'b0;
            end else if ((state_d == ST_OWN1) && (state_q != ST_OWN1)) begin
                last_d = 1'b1;
            end
        end

        case (state_d)
            ST_OWN0: gnt_d = 2'b01;
            ST_OWN1: gnt_d = 2'b10;
            default: gnt_d = 2'b00;
        endcase

        // Display follows the pre-edge index and owner, sampling source data live
        if (state_q == ST_OWN1) begin
            sel_dig_c = src1_dig_i;
        end
        if (state_q != ST_IDLE) begin
            an_d = ~(4'b0001 << idx_q);
            case (idx_q)
                2'd0:    seg_d = sel_dig_c[7:0];
                2'd1:    seg_d = sel_dig_c[15:8];
                2'd2:    seg_d = sel_dig_c[23:16];
                default: seg_d = sel_dig_c[31:24];
            endcase
        end
`ifdef SEG_SCAN_GHOST_BLANK_EN
        if (32'(presc_q) < 32'd16) begin
            an_d = 4'hF;
        end
`else
`endif
    end

    assign gnt_o = gnt_q;
    assign an_o  = an_q;
    assign seg_o = seg_q;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Self-checking bench for seg_scan_arbiter: cycle scoreboard plus directed scenario checks.
module tb_seg_scan_arbiter;

`ifdef SEG_SCAN_GHOST_BLANK_EN
    localparam int RCM   = 31;
    localparam bit GHOST = 1'b1;
`else
    localparam int RCM   = 3;
    localparam bit GHOST = 1'b0;
`endif
    localparam int HOLD = 2;
    localparam int SCAN = 4 * (RCM + 1);

    typedef struct packed {
        logic [1:0] gnt;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [1:0]  req;
    logic [31:0] src0_dig;
    logic [31:0] src1_dig;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t sb_q[$];
    int   m_presc = 0;
    int   m_idx   = 0;
    int   m_state = 0;
    int   m_hold  = 0;
    int   m_last  = 1;

    seg_scan_arbiter #(
        .REFRESH_COUNT_MAX(RCM),
        .HOLD_SCANS       (HOLD)
    ) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .req_i     (req),
        .src0_dig_i(src0_dig),
        .src1_dig_i(src1_dig),
        .gnt_o     (gnt),
        .an_o      (an),
        .seg_o     (seg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_presc = 0;
        m_idx   = 0;
        m_state = 0;
        m_hold  = 0;
        m_last  = 1;
        sb_q.delete();
    endtask

    // Reference: m_state 0 = idle, 1 = source 0 owns, 2 = source 1 owns
    task automatic model_step();
        exp_t        e;
        logic [31:0] d;
        int          nxt;
        int          own;
        int          oth;
        d     = (m_state == 2) ? src1_dig : src0_dig;
        e.an  = 4'hF;
        e.seg = 8'hFF;
        if (m_state != 0) begin
            e.an  = ~(4'b0001 << m_idx);
            e.seg = d[8*m_idx +: 8];
        end
        if (GHOST && m_presc < 16) e.an = 4'hF;
        nxt = m_state;
        if (m_presc == RCM && m_idx == 3) begin
            if (m_state == 0) begin
                if (req == 2'b01)      nxt = 1;
                else if (req == 2'b10) nxt = 2;
                else if (req == 2'b11) nxt = (m_last == 0) ? 2 : 1;
            end else begin
                own = m_state - 1;
                oth = 1 - own;
                if (!req[own])                             nxt = req[oth] ? oth + 1 : 0;
                else if (req[oth] && (m_hold + 1 >= HOLD)) nxt = oth + 1;
            end
            if (nxt != m_state) begin
                m_hold = 0;
                if (nxt != 0) m_last = nxt - 1;
            end else if (m_state != 0 && m_hold < HOLD) begin
                m_hold++;
            end
        end
        m_state = nxt;
        e.gnt = (nxt == 1) ? 2'b01 : (nxt == 2) ? 2'b10 : 2'b00;
        if (m_presc == RCM) begin
            m_presc = 0;
            m_idx   = (m_idx + 1) % 4;
        end else begin
            m_presc++;
        end
        sb_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else       model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb_gnt", 32'(gnt), 32'(e.gnt));
            chk("sb_an",  32'(an),  32'(e.an));
            chk("sb_seg", 32'(seg), 32'(e.seg));
        end
    end

    task automatic wait_gnt(input string tag, input logic [1:0] g, output int n);
        n = 0;
        while (gnt !== g && n < 8 * SCAN) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(gnt), 32'(g));
    endtask

    task automatic wait_an(input string tag, input logic [3:0] a);
        int n;
        n = 0;
        while (an !== a && n < 4 * SCAN) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(an), 32'(a));
    endtask

    initial begin
        int         n;
        logic [3:0] exp_an;
        logic [7:0] bytes0 [4];
        bytes0[0] = 8'hB0;
        bytes0[1] = 8'hA4;
        bytes0[2] = 8'hF9;
        bytes0[3] = 8'hC0;

        reset    = 1'b1;
        req      = 2'b00;
        src0_dig = 32'hC0F9A4B0;
        src1_dig = 32'h8692F8A1;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_an",  32'(an),  32'hF);
        chk("rst_seg", 32'(seg), 32'hFF);
        reset = 1'b0;

        // No requests: display stays blank
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("idle_gnt", 32'(gnt), 32'h0);
            chk("idle_an",  32'(an),  32'hF);
            chk("idle_seg", 32'(seg), 32'hFF);
        end

        // Single requester: digit walk 0..3
        req = 2'b01;
        wait_gnt("grant0", 2'b01, n);
        chk("grant0_an_blank", 32'(an), 32'hF);
        for (int d = 0; d < 4; d++) begin
            for (int k = 0; k <= RCM; k++) begin
                @(negedge clk);
                exp_an = ~(4'b0001 << d);
                if (GHOST && k < 16) exp_an = 4'hF;
                chk("walk_an",  32'(an),  32'(exp_an));
                chk("walk_seg", 32'(seg), 32'(bytes0[d]));
            end
        end

        // Contention from idle: source 0 first, source 1 after the hold
        @(negedge clk);
        reset = 1'b1;
        req   = 2'b11;
        @(negedge clk);
        reset = 1'b0;
        wait_gnt("cont_own0", 2'b01, n);
        chk("cont_own0_lat", 32'(n), 32'(SCAN));
        wait_gnt("cont_own1", 2'b10, n);
        chk("cont_hold_len", 32'(n), 32'(HOLD * SCAN));
        chk("cont_sw_an",  32'(an),  32'h7);
        chk("cont_sw_seg", 32'(seg), 32'hC0);
        @(negedge clk);
        chk("cont_src1_an",  32'(an),  GHOST ? 32'hF : 32'hE);
        chk("cont_src1_seg", 32'(seg), 32'hA1);

        // Owner drops mid-scan: keeps display until boundary
        wait_an("drop_dig1", 4'b1101);
        req = 2'b01;
        wait_gnt("drop_to_own0", 2'b01, n);
        req = 2'b00;
        wait_gnt("drop_to_idle", 2'b00, n);
        @(negedge clk);
        chk("drop_idle_an",  32'(an),  32'hF);
        chk("drop_idle_seg", 32'(seg), 32'hFF);

        // Asynchronous reset mid-dwell of digit 2
        req = 2'b01;
        wait_gnt("arst_grant", 2'b01, n);
        wait_an("arst_dig2", 4'b1011);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_an",  32'(an),  32'hF);
        chk("arst_seg", 32'(seg), 32'hFF);
        chk("arst_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_rel_gnt", 32'(gnt), 32'h0);
        wait_gnt("arst_restart", 2'b01, n);
        chk("arst_restart_lat", 32'(n), 32'(SCAN));

        // Random requests and live data changes
        for (int i = 0; i < 30 * 16; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) req = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                src0_dig = $urandom;
                src1_dig = $urandom;
            end
        end
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
